pwd_store: RTL and testbench
============================

# pwd_store

Parametrised password store for the smart-lock datapath, successor to the fixed 4-entry, 16-bit register file. It holds up to DEPTH codes of DATA_W bits, each with a valid flag, and supports save, delete and registered read. It also provides a sequential match engine that scans all valid slots for an entered code and reports the lowest matching slot. It sits between the keypad/entry logic and the lock-control FSM.

## Interface
- DATA_W, 16, code width in bits
- DEPTH, 4, number of slots (≥2; need not be a power of two)
- AW (localparam), $clog2(DEPTH), slot address width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_W  code to save
- save  in  1  write data_in to save_addr this cycle
- save_addr  in  AW  save target slot
- delete  in  1  invalidate del_addr this cycle
- del_addr  in  AW  delete target slot
- read_addr  in  AW  slot to read
- data_out  out  DATA_W+1  {valid, code} of read_addr, registered
- match_start  in  1  begin scan for match_code
- match_code  in  DATA_W  entered code, sampled on accepted match_start
- match_busy  out  1  scan in progress
- match_done  out  1  one-cycle pulse: scan finished
- match_hit  out  1  last scan found a match; held until next accepted start
- match_addr  out  AW  lowest matching slot; 0 on miss; held like match_hit
- count  out  AW+1  number of valid slots
- full  out  1  count == DEPTH
- op_err  out  1  one-cycle pulse: a request was rejected

## Operation
- Save: slot gets data_in and valid=1. Overwriting a valid slot leaves count unchanged. Saving to an empty slot increments count.
- Delete: valid cleared and data zeroed. Deleting an empty slot is a no-op with no error.
- Save and delete to the same address in the same cycle: delete wins. The slot ends up empty and op_err pulses. Save and delete to different addresses both take effect.
- Address ≥ DEPTH on save or delete: the request is ignored and op_err pulses. Read of address ≥ DEPTH returns 0.
- Match FSM states:
  - IDLE: on match_start, capture match_code, index=0, go to SCAN.
  - SCAN: compare slot[index] against the captured code. On valid && equal, record hit and addr, go to DONE. At the last index without a hit, record a miss and go to DONE. Otherwise increment index.
  - DONE: pulse match_done, go to IDLE.
- While match_busy=1, save, delete and match_start are rejected with op_err, and the store is frozen. This keeps scan results consistent.
- op_err is the OR of all rejections in a cycle.

## Timing
- Reset values: all valid=0, all data=0, data_out=0, count=0, full=0, match_busy=0, match_done=0, match_hit=0, match_addr=0, op_err=0, FSM in IDLE.
- Reset in mid-scan aborts the scan; no match_done is produced.
- Save/delete take effect on the edge where they are sampled. count and full update on the same edge.
- data_out reflects the store state after that edge, with one cycle of latency from read_addr. A read of a slot being saved in cycle t shows the new value in cycle t+1.
- Accepted match_start at cycle t:
  - match_busy is high from t+1.
  - If the first hit is at slot k, match_done is high in cycle t+k+2 and match_busy is high for t+1..t+k+1.
  - On a miss, match_done is high in t+DEPTH+1.
- match_hit and match_addr update in the same cycle match_done rises.
- A new match_start is accepted in the DONE cycle's successor at the earliest.

## Configuration
- PWD_STORE_MASTER_LOCK_EN defined: slot 0 is the master code.
  - Save to slot 0 is accepted only while slot 0 is empty (first enrollment).
  - Delete of a valid slot 0 is always rejected with op_err.
  - Only reset clears slot 0.
- Not defined: slot 0 behaves like every other slot.

## Structure
- Shared package pwd_pkg holds:
  - default DATA_W and DEPTH
  - the match FSM state enum (IDLE, SCAN, DONE)
  - a function returning the {valid, code} entry width
- Natural sub-module: pwd_match_scan, containing the FSM, index counter, captured code and the hit/addr registers. It reads the slot array through an index/entry port.
- The slot array, count and error logic stay in pwd_store.

## Test plan
- Reset; save 16'hFFFF to slot 1; read slot 1 → data_out=17'h1FFFF in the next cycle; count=1.
- Delete slot 1; read slot 1 → data_out=0; count=0. Delete slot 1 again → no op_err.
- Fill all 4 slots (0x1111..0x4444) → full=1. Match 0x3333 at t → match_done at t+4, hit=1, addr=2. Match 0x5555 → done at t+5, hit=0, addr=0.
- Same-cycle save and delete to slot 2 → slot empty, op_err=1. Save during match_busy → op_err=1, store unchanged, scan result correct.
- With PWD_STORE_MASTER_LOCK_EN: save 0xAAAA to empty slot 0 succeeds; delete slot 0 and save 0xBBBB to slot 0 each → op_err=1, slot 0 stays 0xAAAA.
- Assert reset in mid-scan → match_busy=0 next cycle, no match_done, count=0.

Source files
------------

// File: rtl/pwd_pkg.sv
// Shared types and defaults for the password store and its match engine.
package pwd_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } match_state_e;

    // Width of one stored {valid, code} entry.
    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/pwd_match_scan.sv
// Sequential match engine: walks slots 0..DEPTH-1 and reports the lowest valid slot equal to the code.
module pwd_match_scan
    import pwd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned EW = entry_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] code,
    input  logic [EW-1:0]     entry,
    output logic [AW-1:0]     idx,
    output logic              idle_c,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [AW-1:0]     addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    match_state_e      state;
    logic [DATA_W-1:0] code_q;

    assign idle_c = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            code_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hit    <= 1'b0;
            addr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        code_q <= code;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (entry[EW-1] && (entry[DATA_W-1:0] == code_q)) begin
                        hit   <= 1'b1;
                        addr  <= idx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        hit   <= 1'b0;
                        addr  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwd_store.sv
// Parametrised password store with save/delete/read and a sequential match engine.
// Define PWD_STORE_MASTER_LOCK_EN to make slot 0 a write-once master code (cleared only by reset).
module pwd_store
    import pwd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned EW = entry_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              save,
    input  logic [AW-1:0]     save_addr,
    input  logic              delete,
    input  logic [AW-1:0]     del_addr,
    input  logic [AW-1:0]     read_addr,
    output logic [EW-1:0]     data_out,
    input  logic              match_start,
    input  logic [DATA_W-1:0] match_code,
    output logic              match_busy,
    output logic              match_done,
    output logic              match_hit,
    output logic [AW-1:0]     match_addr,
    output logic [AW:0]       count,
    output logic              full,
    output logic              op_err
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [AW:0]       cnt_d;
    logic              err_d;
    logic              save_ok, del_ok;
    logic [EW-1:0]     rd_entry;
    logic [AW-1:0]     scan_idx;
    logic [EW-1:0]     scan_entry_c;
    logic              scan_idle_c;
    logic              start_acc;

    assign start_acc    = match_start && scan_idle_c;
    assign scan_entry_c = {valid_q[scan_idx], data_q[scan_idx]};

    // Next store state and rejection flags; the store is frozen while a scan runs.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = 1'b0;
        save_ok = 1'b0;
        del_ok  = 1'b0;
        if (match_busy) begin
            err_d = save || delete || match_start;
        end else begin
            if (match_start && !scan_idle_c) err_d = 1'b1;
            if (save && !(32'(save_addr) < DEPTH)) err_d = 1'b1;
            if (delete && !(32'(del_addr) < DEPTH)) err_d = 1'b1;
            save_ok = save && (32'(save_addr) < DEPTH);
            del_ok  = delete && (32'(del_addr) < DEPTH);
            if (save_ok && del_ok && (save_addr == del_addr)) begin
                err_d   = 1'b1;
                save_ok = 1'b0;
            end
`ifdef PWD_STORE_MASTER_LOCK_EN
            if (save_ok && (save_addr == '0) && valid_q[0]) begin
                err_d   = 1'b1;
                save_ok = 1'b0;
            end
            if (del_ok && (del_addr == '0) && valid_q[0]) begin
                err_d  = 1'b1;
                del_ok = 1'b0;
            end
`endif
            if (save_ok) begin
                valid_d[save_addr] = 1'b1;
                data_d[save_addr]  = data_in;
            end
            if (del_ok) begin
                valid_d[del_addr] = 1'b0;
                data_d[del_addr]  = '0;
            end
        end
    end

    // Population count of the post-edge valid vector keeps count exact for any save/delete mix.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_d = cnt_d + (AW+1)'(valid_d[i]);
        end
    end

    // Read port shows post-edge contents so a same-cycle save is visible next cycle.
    always_comb begin
        rd_entry = '0;
        if (32'(read_addr) < DEPTH) begin
            rd_entry = {valid_d[read_addr], data_d[read_addr]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
            data_out <= '0;
            count    <= '0;
            full     <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
            data_out <= rd_entry;
            count    <= cnt_d;
            full     <= (cnt_d == CNT_FULL);
            op_err   <= err_d;
        end
    end

    pwd_match_scan #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .start  (start_acc),
        .code   (match_code),
        .entry  (scan_entry_c),
        .idx    (scan_idx),
        .idle_c (scan_idle_c),
        .busy   (match_busy),
        .done   (match_done),
        .hit    (match_hit),
        .addr   (match_addr)
    );

endmodule

// File: tb/tb_pwd_store.sv
// Directed self-checking bench for pwd_store (DATA_W=16, DEPTH=4).
module tb_pwd_store;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        save;
    logic [1:0]  save_addr;
    logic        delete;
    logic [1:0]  del_addr;
    logic [1:0]  read_addr;
    logic [16:0] data_out;
    logic        match_start;
    logic [15:0] match_code;
    logic        match_busy;
    logic        match_done;
    logic        match_hit;
    logic [1:0]  match_addr;
    logic [2:0]  count;
    logic        full;
    logic        op_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwd_store dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .save        (save),
        .save_addr   (save_addr),
        .delete      (delete),
        .del_addr    (del_addr),
        .read_addr   (read_addr),
        .data_out    (data_out),
        .match_start (match_start),
        .match_code  (match_code),
        .match_busy  (match_busy),
        .match_done  (match_done),
        .match_hit   (match_hit),
        .match_addr  (match_addr),
        .count       (count),
        .full        (full),
        .op_err      (op_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        save        = 1'b0;
        delete      = 1'b0;
        match_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        data_in     = '0;
        save        = 1'b0;
        save_addr   = '0;
        delete      = 1'b0;
        del_addr    = '0;
        read_addr   = '0;
        match_start = 1'b0;
        match_code  = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_busy", 32'(match_busy), 32'h0);
        chk("rst_done", 32'(match_done), 32'h0);
        chk("rst_hit", 32'(match_hit), 32'h0);
        chk("rst_addr", 32'(match_addr), 32'h0);
        chk("rst_op_err", 32'(op_err), 32'h0);

        // Save FFFF to slot 1 and read it back next cycle.
        save = 1'b1; save_addr = 2'd1; data_in = 16'hFFFF; read_addr = 2'd1;
        tick();
        idle_inputs();
        chk("save1_data_out", 32'(data_out), 32'h1FFFF);
        chk("save1_count", 32'(count), 32'h1);
        chk("save1_op_err", 32'(op_err), 32'h0);

        // Delete slot 1, then delete it again (no-op, no error).
        delete = 1'b1; del_addr = 2'd1;
        tick();
        chk("del1_data_out", 32'(data_out), 32'h0);
        chk("del1_count", 32'(count), 32'h0);
        chk("del1_op_err", 32'(op_err), 32'h0);
        tick();
        idle_inputs();
        chk("del1_again_op_err", 32'(op_err), 32'h0);
        chk("del1_again_count", 32'(count), 32'h0);

        // Fill all slots with 1111..4444.
        for (int i = 0; i < 4; i++) begin
            save = 1'b1; save_addr = 2'(i); data_in = 16'(16'h1111 * (i + 1));
            tick();
        end
        idle_inputs();
        chk("fill_count", 32'(count), 32'h4);
        chk("fill_full", 32'(full), 32'h1);
        read_addr = 2'd3;
        tick();
        chk("fill_read3", 32'(data_out), 32'h14444);

        // Match 3333 (slot 2): done at t+4.
        match_start = 1'b1; match_code = 16'h3333;
        tick();
        match_start = 1'b0;
        chk("m3_busy_t1", 32'(match_busy), 32'h1);
        tick();
        tick();
        chk("m3_done_t3", 32'(match_done), 32'h0);
        chk("m3_busy_t3", 32'(match_busy), 32'h1);
        tick();
        chk("m3_done_t4", 32'(match_done), 32'h1);
        chk("m3_hit", 32'(match_hit), 32'h1);
        chk("m3_addr", 32'(match_addr), 32'h2);
        chk("m3_busy_t4", 32'(match_busy), 32'h0);
        tick();
        chk("m3_done_t5", 32'(match_done), 32'h0);

        // Match 5555 (miss): done at t+5.
        match_start = 1'b1; match_code = 16'h5555;
        tick();
        match_start = 1'b0;
        tick();
        tick();
        tick();
        chk("m5_done_t4", 32'(match_done), 32'h0);
        tick();
        chk("m5_done_t5", 32'(match_done), 32'h1);
        chk("m5_hit", 32'(match_hit), 32'h0);
        chk("m5_addr", 32'(match_addr), 32'h0);
        tick();

        // Same-cycle save and delete to slot 2: delete wins with op_err.
        save = 1'b1; save_addr = 2'd2; data_in = 16'h9999;
        delete = 1'b1; del_addr = 2'd2; read_addr = 2'd2;
        tick();
        idle_inputs();
        chk("sd_op_err", 32'(op_err), 32'h1);
        chk("sd_data_out", 32'(data_out), 32'h0);
        chk("sd_count", 32'(count), 32'h3);
        chk("sd_full", 32'(full), 32'h0);
        tick();
        chk("sd_op_err_clear", 32'(op_err), 32'h0);

        // Save while busy is rejected; scan for 4444 (slot 3) still completes at t+5.
        match_start = 1'b1; match_code = 16'h4444;
        tick();
        match_start = 1'b0;
        save = 1'b1; save_addr = 2'd2; data_in = 16'h7777;
        tick();
        idle_inputs();
        chk("busy_save_op_err", 32'(op_err), 32'h1);
        chk("busy_save_data_out", 32'(data_out), 32'h0);
        chk("busy_save_count", 32'(count), 32'h3);
        tick();
        tick();
        chk("m4_done_t4", 32'(match_done), 32'h0);
        tick();
        chk("m4_done_t5", 32'(match_done), 32'h1);
        chk("m4_hit", 32'(match_hit), 32'h1);
        chk("m4_addr", 32'(match_addr), 32'h3);
        tick();

`ifdef PWD_STORE_MASTER_LOCK_EN
        // Master slot: first enrollment accepted, later delete/overwrite rejected.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        save = 1'b1; save_addr = 2'd0; data_in = 16'hAAAA; read_addr = 2'd0;
        tick();
        idle_inputs();
        chk("ml_save_op_err", 32'(op_err), 32'h0);
        chk("ml_save_data", 32'(data_out), 32'h1AAAA);
        delete = 1'b1; del_addr = 2'd0;
        tick();
        idle_inputs();
        chk("ml_del_op_err", 32'(op_err), 32'h1);
        chk("ml_del_data", 32'(data_out), 32'h1AAAA);
        save = 1'b1; save_addr = 2'd0; data_in = 16'hBBBB;
        tick();
        idle_inputs();
        chk("ml_resave_op_err", 32'(op_err), 32'h1);
        chk("ml_resave_data", 32'(data_out), 32'h1AAAA);
        chk("ml_count", 32'(count), 32'h1);
        tick();
`endif

        // Reset in mid-scan aborts without a done pulse.
        match_start = 1'b1; match_code = 16'h4444;
        tick();
        match_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rscan_busy", 32'(match_busy), 32'h0);
        chk("rscan_done", 32'(match_done), 32'h0);
        chk("rscan_count", 32'(count), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rscan_no_done", 32'(match_done), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
